// File: rtl/md_unit_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_unit_param: parametrised HI/LO multiply/divide unit for the E stage.     |
// | Optional macro MD_FAST_DIV_EN selects a behavioural fixed-latency divider.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [3:0]       md_sel,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             md_busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] md_out
);

  localparam int c_lat_max = (WIDTH > MUL_LAT) ? ((WIDTH > DIV_LAT) ? WIDTH : DIV_LAT)
                                               : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
  localparam int c_cw = $clog2(c_lat_max + 1);
  localparam logic [c_cw-1:0] c_mul_cnt = c_cw'(MUL_LAT);
  localparam logic [c_cw-1:0] c_one     = c_cw'(1);
`ifdef MD_FAST_DIV_EN
  localparam logic [c_cw-1:0] c_div_cnt = c_cw'(DIV_LAT);
`else
  localparam logic [c_cw-1:0] c_div_cnt = c_cw'(WIDTH);
`endif

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mfhi  = 4'd5;
  localparam logic [3:0] c_op_mflo  = 4'd6;
  localparam logic [3:0] c_op_mthi  = 4'd7;
  localparam logic [3:0] c_op_mtlo  = 4'd8;
  localparam logic [3:0] c_op_madd  = 4'd9;
  localparam logic [3:0] c_op_maddu = 4'd10;
  localparam logic [3:0] c_op_msub  = 4'd11;
  localparam logic [3:0] c_op_msubu = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [2*WIDTH-1:0] r_tmp;
  logic [c_cw-1:0]    r_cnt;
  logic               r_busy;

  logic w_accept, w_is_mul, w_is_div, w_signed, w_last, w_dz, w_d1_neg;

  assign w_accept = (r_state == S_IDLE) && !req;
  assign w_last   = (r_cnt == c_one);
  assign w_dz     = (d2 == '0);
  assign w_d1_neg = w_signed & d1[WIDTH-1];

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    case (md_sel)
      c_op_mult:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      c_op_multu: w_is_mul = 1'b1;
      c_op_div:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      c_op_divu:  w_is_div = 1'b1;
      c_op_madd:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      c_op_maddu: w_is_mul = 1'b1;
      c_op_msub:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      c_op_msubu: w_is_mul = 1'b1;
      default:    ;
    endcase
  end

  // Sign/zero-extend to 2*WIDTH so one unsigned multiplier serves both flavours.
  logic [2*WIDTH-1:0] w_ext1, w_ext2, w_prod, w_hilo, w_mul_res;
  assign w_ext1 = {{WIDTH{w_d1_neg}}, d1};
  assign w_ext2 = {{WIDTH{w_signed & d2[WIDTH-1]}}, d2};
  assign w_prod = w_ext1 * w_ext2;
  assign w_hilo = {r_hi, r_lo};

  always_comb begin
    w_mul_res = w_prod;
    case (md_sel)
      c_op_madd, c_op_maddu: w_mul_res = w_hilo + w_prod;
      c_op_msub, c_op_msubu: w_mul_res = w_hilo - w_prod;
      default:               ;
    endcase
  end

`ifdef MD_FAST_DIV_EN
  // Substitute a safe divisor so the behavioural operators never see /0 or MIN/-1.
  logic               w_ovf;
  logic [WIDTH-1:0]   w_dvs_safe, w_uq, w_ur, w_q, w_r;
  logic signed [WIDTH-1:0] w_sq, w_sr;

  assign w_ovf      = w_signed && (d1 == {1'b1, {(WIDTH-1){1'b0}}}) && (d2 == '1);
  assign w_dvs_safe = (w_dz || w_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : d2;
  assign w_sq       = $signed(d1) / $signed(w_dvs_safe);
  assign w_sr       = $signed(d1) % $signed(w_dvs_safe);
  assign w_uq       = d1 / w_dvs_safe;
  assign w_ur       = d1 % w_dvs_safe;

  always_comb begin
    w_q = w_uq;
    w_r = w_ur;
    if (w_dz) begin
      w_q = '1;
      w_r = d1;
    end else if (w_ovf) begin
      w_q = d1;
      w_r = '0;
    end else if (w_signed) begin
      w_q = w_sq;
      w_r = w_sr;
    end
  end
`else
  // r_tmp holds {remainder, dividend/quotient}; quotient bits shift in at the LSB.
  logic             r_q_neg, r_r_neg;
  logic [WIDTH-1:0] r_dvs, w_dividend, w_divisor;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_ge;

  assign w_dividend = (w_d1_neg && !w_dz) ? -d1 : d1;
  assign w_divisor  = (w_signed && d2[WIDTH-1]) ? -d2 : d2;
  assign w_shift    = {r_tmp[2*WIDTH-1:WIDTH], r_tmp[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_ge       = ~w_diff[WIDTH];
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
        else if (w_accept && w_is_div) w_state_nxt = S_DIV;
      end
      S_MUL: if (w_last) w_state_nxt = S_IDLE;
`ifdef MD_FAST_DIV_EN
      S_DIV: if (w_last) w_state_nxt = S_IDLE;
`else
      S_DIV: if (w_last) w_state_nxt = S_FIX;
`endif
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_tmp   <= '0;
      r_cnt   <= '0;
`ifndef MD_FAST_DIV_EN
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_tmp <= w_mul_res;
              r_cnt <= c_mul_cnt;
            end else if (w_is_div) begin
              r_cnt <= c_div_cnt;
`ifdef MD_FAST_DIV_EN
              r_tmp <= {w_r, w_q};
`else
              // Divide by zero keeps the raw dividend and skips sign fixup.
              r_tmp   <= {{WIDTH{1'b0}}, w_dividend};
              r_dvs   <= w_divisor;
              r_q_neg <= !w_dz && (w_d1_neg ^ (w_signed & d2[WIDTH-1]));
              r_r_neg <= !w_dz && w_d1_neg;
`endif
            end else if (md_sel == c_op_mthi) begin
              r_hi <= d1;
            end else if (md_sel == c_op_mtlo) begin
              r_lo <= d1;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt - c_one;
          if (w_last) {r_hi, r_lo} <= r_tmp;
        end
        S_DIV: begin
          r_cnt <= r_cnt - c_one;
`ifdef MD_FAST_DIV_EN
          if (w_last) {r_hi, r_lo} <= r_tmp;
`else
          r_tmp[2*WIDTH-1:WIDTH] <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_tmp[WIDTH-1:0]       <= {r_tmp[WIDTH-2:0], w_ge};
`endif
        end
        S_FIX: begin
`ifndef MD_FAST_DIV_EN
          r_lo <= r_q_neg ? -r_tmp[WIDTH-1:0] : r_tmp[WIDTH-1:0];
          r_hi <= r_r_neg ? -r_tmp[2*WIDTH-1:WIDTH] : r_tmp[2*WIDTH-1:WIDTH];
`endif
        end
        default: ;
      endcase
    end
  end

  assign md_busy  = r_busy;
  assign md_stall = r_busy & (md_sel != 4'd0);

  always_comb begin
    md_out = '0;
    case (md_sel)
      c_op_mfhi: md_out = r_hi;
      c_op_mflo: md_out = r_lo;
      default:   ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_md_unit_param.sv
`default_nettype none
// tb_md_unit_param: randomized self-checking bench for md_unit_param against
// an arithmetic HI/LO reference model.
module tb_md_unit_param;

`ifdef MD_FAST_DIV_EN
  localparam int DIV_BUSY = 10;
`else
  localparam int DIV_BUSY = 33;
`endif

  logic        clk = 1'b0, reset = 1'b1, req = 1'b0;
  logic [3:0]  md_sel = 4'd0;
  logic [31:0] d1 = '0, d2 = '0;
  logic        md_busy, md_stall;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  md_unit_param dut (
    .clk(clk), .reset(reset), .req(req), .md_sel(md_sel), .d1(d1), .d2(d2),
    .md_busy(md_busy), .md_stall(md_stall), .md_out(md_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc, p;
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {m_hi, m_lo};
    p   = 64'(sa * sb);
    if (op == 4'd2 || op == 4'd10 || op == 4'd12) p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1, 4'd2:  acc = p;
      4'd9, 4'd10: acc = acc + p;
      4'd11, 4'd12: acc = acc - p;
      default: ;
    endcase
    {m_hi, m_lo} = acc;
    if (op == 4'd3 || op == 4'd4) begin
      if (b == 0) begin
        m_lo = '1; m_hi = a;
      end else if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_lo = a; m_hi = 0;
      end else if (op == 4'd3) begin
        m_lo = $signed(a) / $signed(b); m_hi = $signed(a) % $signed(b);
      end else begin
        m_lo = a / b; m_hi = a % b;
      end
    end
    if (op == 4'd7) m_hi = a;
    if (op == 4'd8) m_lo = a;
  endfunction

  function automatic int lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12: return 5;
      4'd3, 4'd4: return DIV_BUSY;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Present op for one cycle, scramble md_sel while busy, return busy-cycle count.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk); md_sel = op; d1 = a; d2 = b;
    @(posedge clk); #1; md_sel = 4'd0; d1 = $urandom; d2 = $urandom;
    n = 0;
    while (md_busy === 1'b1 && n < 200) begin
      n++;
      md_sel = 4'($urandom);
      @(posedge clk); #1;
    end
    md_sel = 4'd0;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk); md_sel = 4'd5; #1 hi = md_out;
    md_sel = 4'd6; #1 lo = md_out; md_sel = 4'd0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #10;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", md_busy); end
    md_sel = 4'd5; #1;
    checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", md_out); end
    md_sel = 4'd6; #1;
    checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", md_out); end
    md_sel = 4'd0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mult();
    logic [3:0] ops [6] = '{4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12};
    logic [3:0] dop [6] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd10, 4'd11};
    logic [31:0] da [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd2};
    logic [31:0] db [6] = '{32'd3, 32'd3, 32'd0, 32'd0, 32'd1, 32'd3};
    logic [31:0] hi, lo, a, b;
    logic [3:0] op;
    int n;
    for (int i = 0; i < 30; i++) begin
      if (i < 6) begin op = dop[i]; a = da[i]; b = db[i]; end
      else begin
        op = ops[$urandom_range(0, 5)]; a = rnd_val(); b = rnd_val();
        if ($urandom_range(0, 3) == 0) begin
          issue(4'd7, $urandom, 0, n); model(4'd7, d1, 0);
          m_hi = 32'h0; issue(4'd7, 32'h0, 0, n);
        end
      end
      issue(op, a, b, n); model(op, a, b); read_hilo(hi, lo);
      checks++; if (n !== lat(op)) begin errors++; $display("FAIL mul_busy op=%0d got %0d want %0d", op, n, lat(op)); end
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++;
        $display("FAIL mul_hilo op=%0d a=%h b=%h got %h_%h want %h_%h", op, a, b, hi, lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_div();
    logic [31:0] da [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [31:0] db [4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [3:0]  dop [4] = '{4'd3, 4'd4, 4'd3, 4'd3};
    logic [31:0] hi, lo, a, b;
    logic [3:0] op;
    int n;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin op = dop[i]; a = da[i]; b = db[i]; end
      else begin op = 4'($urandom_range(3, 4)); a = rnd_val(); b = rnd_val(); end
      issue(op, a, b, n); model(op, a, b); read_hilo(hi, lo);
      checks++; if (n !== DIV_BUSY) begin errors++; $display("FAIL div_busy got %0d want %0d", n, DIV_BUSY); end
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++;
        $display("FAIL div_hilo op=%0d a=%h b=%h got %h_%h want %h_%h", op, a, b, hi, lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, b;
    int n;
    a = $urandom; b = $urandom;
    @(negedge clk); md_sel = 4'd1; d1 = a; d2 = b; #1;
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_accept got %0b want 0", md_stall); end
    @(posedge clk); #1; md_sel = 4'd6;
    n = 0;
    while (md_busy === 1'b1 && n < 200) begin
      checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_hold got %0b want 1", md_stall); end
      n++; @(posedge clk); #1;
    end
    model(4'd1, a, b);
    checks++; if (n !== 5) begin errors++; $display("FAIL stall_len got %0d want 5", n); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_release got %0b want 0", md_stall); end
    checks++; if (md_out !== m_lo) begin errors++; $display("FAIL stall_mflo got %h want %h", md_out, m_lo); end
    md_sel = 4'd0;
  endtask

  task automatic test_req();
    logic [31:0] hi, lo, a, b;
    int n;
    issue(4'd7, 32'h1234_5678, 0, n); model(4'd7, 32'h1234_5678, 0);
    issue(4'd8, 32'h9ABC_DEF0, 0, n); model(4'd8, 32'h9ABC_DEF0, 0);
    @(negedge clk); req = 1'b1; md_sel = 4'd1; d1 = $urandom; d2 = $urandom;
    @(posedge clk); #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL req_mult_busy got %0b want 0", md_busy); end
    @(negedge clk); md_sel = 4'd8; d1 = 32'd5;
    @(negedge clk); md_sel = 4'd13;
    @(posedge clk); #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL req_none_busy got %0b want 0", md_busy); end
    req = 1'b0; md_sel = 4'd0;
    read_hilo(hi, lo);
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL req_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    a = $urandom; b = 32'($urandom_range(1, 1000));
    @(negedge clk); md_sel = 4'd3; d1 = a; d2 = b;
    @(posedge clk); #1; md_sel = 4'd0; req = 1'b1;
    n = 0;
    while (md_busy === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
    model(4'd3, a, b);
    md_sel = 4'd1;
    repeat (2) @(posedge clk); #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL req_after_div_busy got %0b want 0", md_busy); end
    md_sel = 4'd0; req = 1'b0;
    read_hilo(hi, lo);
    checks++; if (n !== DIV_BUSY) begin errors++; $display("FAIL req_div_len got %0d want %0d", n, DIV_BUSY); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL req_div_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_async_reset();
    logic [31:0] hi, lo, a, b;
    int n;
    issue(4'd7, 32'hDEAD_BEEF, 0, n);
    issue(4'd8, 32'hCAFE_F00D, 0, n);
    @(negedge clk); md_sel = 4'd3; d1 = $urandom; d2 = 32'd3;
    @(posedge clk); #1; md_sel = 4'd0;
    repeat (9) @(posedge clk);
    #3;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %0b want 1", md_busy); end
    reset = 1'b0; #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %0b want 0", md_busy); end
    md_sel = 4'd5; #1;
    checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL arst_hi got %h want 0", md_out); end
    md_sel = 4'd6; #1;
    checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL arst_lo got %h want 0", md_out); end
    md_sel = 4'd0; m_hi = 0; m_lo = 0;
    @(negedge clk); reset = 1'b1;
    a = $urandom; b = $urandom;
    issue(4'd1, a, b, n); model(4'd1, a, b); read_hilo(hi, lo);
    checks++; if (n !== 5) begin errors++; $display("FAIL arst_mult_busy got %0d want 5", n); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL arst_mult_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo, a, b;
    logic [3:0] op;
    int n;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom); a = rnd_val(); b = rnd_val();
      issue(op, a, b, n); model(op, a, b);
      checks++; if (n !== lat(op)) begin errors++; $display("FAIL b2b_busy op=%0d got %0d want %0d", op, n, lat(op)); end
    end
    read_hilo(hi, lo);
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL b2b_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_req();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS CPU; successor to the fixed 32-bit MDU.
- Holds HI/LO architectural registers and runs mult/multu/div/divu plus the new madd/maddu/msub/msubu accumulate ops.
- Drives a stall request to hazard control and suppresses issue when an exception request is pending.
- Default divider is a bit-serial restoring divider instead of a behavioural `/` and `%`.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and ≥ 8.
- MUL_LAT, 5, busy cycles for multiply and multiply-accumulate ops; must be ≥ 1.
- DIV_LAT, 10, busy cycles for divide; used only when MD_FAST_DIV_EN is defined.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- req, input, 1, exception/interrupt pending; blocks issue this cycle.
- md_sel, input, 4, operation select:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
  - 9 madd, 10 maddu, 11 msub, 12 msubu; values 13–15 are treated as none.
- d1, input, WIDTH, rs operand.
- d2, input, WIDTH, rt operand.
- md_busy, output, 1, registered; an operation is in flight.
- md_stall, output, 1, combinational; `md_busy & (md_sel != 0)`.
- md_out, output, WIDTH, combinational; HI for mfhi, LO for mflo, otherwise 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - HI, LO, temporaries and count are cleared to 0; state goes to IDLE; md_busy=0.
  - Applies mid-operation: the in-flight result is discarded.
- State machine: IDLE, MUL, DIV, FIX.
- Accept rule: an op is accepted only in IDLE with req=0; it is accepted in that same cycle.
  - md_stall is 0 during the accepting cycle, so the issuing instruction advances.
  - md_busy rises on the next edge.
- mthi/mtlo in IDLE with req=0: HI or LO takes d1 on the edge. In all other cases they are blocked by stall or req.
- mfhi/mflo: combinational read of the committed HI/LO.
  - A stale read is impossible because md_stall holds the reader while busy.
- req=1: no op is accepted and mt* writes are dropped.
  - An op already in MUL/DIV/FIX continues and commits normally.
- Multiply path (MUL state):
  - At accept, compute the 2*WIDTH product into TMP; the `_u` ops are zero-extended, the others signed.
  - madd/maddu: TMP = {HI,LO} + product.
  - msub/msubu: TMP = {HI,LO} - product.
  - All arithmetic is modulo 2^(2*WIDTH); carry out is ignored.
  - count = MUL_LAT; decrement each cycle. When count reaches 1, {HI,LO} <= TMP, return to IDLE, md_busy falls.
  - md_busy is high for exactly MUL_LAT cycles.
- Divide path (iterative, default):
  - Accept: latch |d1| and |d2| (signed ops) or raw values (unsigned), and latch the quotient and remainder signs.
  - DIV: WIDTH restoring iterations, one quotient bit per cycle, MSB first.
  - FIX: one cycle. Negate the quotient if the operand signs differ; negate the remainder if the dividend was negative. Then LO <= quotient, HI <= remainder and return to IDLE.
  - md_busy is high for WIDTH+1 cycles.
- Divide boundary cases:
  - Divisor 0: no trap. LO = all ones and HI = d1, for both signed and unsigned; the signed fixup is skipped.
  - Signed MIN / -1: LO = MIN, HI = 0.
  - Truncation is toward zero; the remainder takes the sign of the dividend.
- HI/LO commit only at op completion; mt* during busy cannot occur because of stall.
- md_sel changes while busy do not affect the in-flight op; operands are latched at accept.

Optional Feature:
- Macro: MD_FAST_DIV_EN.
- Defined:
  - The divide result is computed at accept with behavioural signed/unsigned `/` and `%`.
  - The divide-by-zero and MIN/-1 cases are overridden to the values above.
  - The unit waits DIV_LAT busy cycles in DIV, FIX is skipped, and commit happens when count reaches 1.
- Undefined: the iterative divider with WIDTH+1 busy cycles, as above.
- The results are identical in both builds; only the latency differs.

Test Plan:
- mult d1=0xFFFFFFFE (-2), d2=3 -> md_busy high 5 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- mthi 1, mtlo 0xFFFFFFFF, then maddu d1=1, d2=1 -> HI=2, LO=0. Then msub d1=2, d2=3 -> {HI,LO}=0x00000001_FFFFFFFA.
- div d1=-7 (0xFFFFFFF9), d2=2 -> md_busy high 33 cycles (fast build: 10); LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> LO=0xFFFFFFFF, HI=7. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mult accepted, then mflo presented the next cycle -> md_stall=1 until md_busy falls; md_out equals the new LO once the stall drops.
- req=1 in the same cycle as mult or mtlo 5 -> md_busy stays 0 and HI/LO unchanged. req=1 while a div is in flight -> the div still commits correctly.
- reset pulsed low asynchronously mid-div (cycle 10) -> md_busy=0 and HI=LO=0 immediately, without waiting for a clock edge; the next mult works normally.
